// File: rtl/mips_encode_stream_if.sv
// rtl/mips_encode_stream_if.sv - request/response stream bundle for the MIPS encoder
interface mips_encode_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src2;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_except;

  // Producer of requests and consumer of encoded words
  modport master (
    output in_valid, alu_op, alu_src2, rs, rt, rd, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_except
  );

  // The encoder itself
  modport slave (
    input  in_valid, alu_op, alu_src2, rs, rt, rd, imm, out_ready,
    output in_ready, out_valid, out_instr, out_except
  );
endinterface

// File: rtl/mips_encode_stream.sv
// rtl/mips_encode_stream.sv - MIPS arithmetic instruction encoder with output FIFO
module mips_encode_stream #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  mips_encode_stream_if.slave      bus,
  output logic [CW-1:0]            illegal_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] prev_ptr;
  logic [32:0]   head;
  logic          legal;
  logic [31:0]   word;
  logic [5:0]    funct;
  logic [5:0]    opcode;
  logic          push;
  logic          pop;

  // Decode the op/src2 pair into funct or opcode and build the instruction word
  always_comb begin
    legal  = 1'b0;
    funct  = 6'h00;
    opcode = 6'h00;
    word   = 32'h0;
    case (bus.alu_src2)
      2'b00: begin
        legal = 1'b1;
        case (bus.alu_op)
          3'b010:  funct = 6'h20;
          3'b011:  funct = 6'h22;
          3'b100:  funct = 6'h24;
          3'b101:  funct = 6'h25;
          3'b110:  funct = 6'h27;
          3'b111:  funct = 6'h26;
          default: legal = 1'b0;
        endcase
      end
      2'b01: begin
        if (bus.alu_op == 3'b010) begin
          legal  = 1'b1;
          opcode = 6'h08;
        end
      end
      2'b10: begin
        case (bus.alu_op)
          3'b100:  begin legal = 1'b1; opcode = 6'h0C; end
          3'b101:  begin legal = 1'b1; opcode = 6'h0D; end
          3'b111:  begin legal = 1'b1; opcode = 6'h0E; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      if (bus.alu_src2 == 2'b00)
        word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, funct};
      else
        word = {opcode, bus.rs, bus.rt, bus.imm};
    end
  end

  assign bus.in_ready  = (level != FULL_LEVEL);
  assign bus.out_valid = (level != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // When empty, show the slot just popped so the outputs hold their last value
  assign prev_ptr       = rd_ptr - AW'(1);
  assign head           = bus.out_valid ? mem[rd_ptr] : mem[prev_ptr];
  assign bus.out_instr  = head[31:0];
  assign bus.out_except = head[32];

  // FIFO storage, pointers, occupancy and the saturating illegal-request counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      illegal_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {~legal, word};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (!push && pop)
        level <= level - LW'(1);
      if (push && !legal && (illegal_count != '1))
        illegal_count <= illegal_count + CW'(1);
    end
  end
endmodule

// File: doc/mips_encode_stream.md
Name: mips_encode_stream

Overview:
- Streaming MIPS arithmetic-instruction encoder. It is the inverse of the arithmetic decoder.
- Accepts decoded control fields and register/immediate operands on a valid/ready input.
- Packs them into a 32-bit MIPS instruction word and buffers the words in a DEPTH-entry FIFO toward a valid/ready consumer.
- Used by the instruction-generation/test side of the datapath to produce words the decoder must round-trip.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- CW, 8, width of the illegal-request counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept
- alu_op  in  3  010 add, 011 sub, 100 and, 101 or, 110 nor, 111 xor; 000/001 illegal
- alu_src2  in  2  00 register (R-type), 01 sign-ext imm, 10 zero-ext imm, 11 illegal
- rs  in  5  source register
- rt  in  5  second source (R) / destination (I)
- rd  in  5  destination (R-type only)
- imm  in  16  immediate (I-type only)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  encoded instruction
- out_except  out  1  head entry was an illegal request
- illegal_count  out  CW  saturating count of accepted illegal requests
- level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, active-low) clears:
  - FIFO pointers; level=0; out_valid=0; out_instr=0; out_except=0; illegal_count=0.
  - in_ready=1 on the first clock after release.
- Encode is combinational on the inputs and captured into the FIFO on the push edge.
- R-type (alu_src2=00):
  - Word is {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - funct: add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27.
  - imm is ignored.
- I-type: word is {opcode, rs, rt, imm}. rd is ignored.
  - alu_src2=01 is legal only with add: opcode 0x08 (addi).
  - alu_src2=10 is legal only with and/or/xor: opcode 0x0C (andi), 0x0D (ori), 0x0E (xori).
- Illegal cases: alu_op 000/001, alu_src2=11, or a src2/op mismatch.
  - Entry pushed with instr=32'h0 and except=1.
  - illegal_count increments, saturating at all-ones.
  - Illegal entries are never dropped and keep their order.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (level != DEPTH). It is registered-state-derived only and does not depend on out_ready.
- Full: in_ready=0. A simultaneous pop that cycle does not permit a push; in_ready rises the next cycle.
- Empty: out_valid=0; out_instr and out_except hold their last value (0 after reset).
- Latency: a word accepted at edge N appears at the head no earlier than edge N+1, with no combinational in->out path.
- Simultaneous push and pop when neither full nor empty: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- out_instr/out_except are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream: all buffered entries are discarded immediately, without waiting for a clock edge.

Test Plan:
1. After reset, push add rs=1 rt=2 rd=3 with out_ready=1 -> next cycle out_valid=1, out_instr=0x00221820, out_except=0, level returns to 0.
2. Push addi (alu_op=010, alu_src2=01) rs=1 rt=2 imm=0xFFFF, then ori (101, 10) rs=4 rt=5 imm=0x1234, then nor R-type rs=5 rt=6 rd=7.
   - Expected output, in order: 0x2022FFFF, 0x34851234, 0x00A63827.
3. Illegal requests: alu_op=011 with alu_src2=01, then alu_src2=11.
   - Expected: two entries with out_instr=0, out_except=1; illegal_count=2.
   - 300 illegal pushes -> illegal_count saturates at 255.
4. out_ready=0, push 5 legal words -> in_ready=0 after 4 accepts, level=4, 5th in_valid held.
   - Then pulse out_ready one cycle: 5th accepted the following cycle, FIFO order preserved across pointer wrap.
5. Continuous push and pop at level=2 for 16 cycles -> level constant at 2, all 16 words emerge in order.
6. Assert reset with level=3 and illegal_count=5 -> out_valid=0, level=0, illegal_count=0 asynchronously. The first push after release emerges correctly.
